wash_sequencer: RTL and testbench

- Parametrised successor to the single-pass wash controller.
- Runs NUM_PASSES fill/shake passes, then a spin-dry (turn) phase.
- Shake and turn durations come from internal cycle timers rather than an external time input.
- Adds a fill timeout fault, pause, abort, a done pulse and status outputs. Sits between the front-panel start logic and the valve and motor drivers.

---
 rtl/wash_sequencer.sv | 134 +++++++++++++
 tb/tb_wash_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Multi-pass wash sequencer: NUM_PASSES fill/shake passes followed by a spin-dry turn,
// with a fill timeout fault, pause, abort, and a done pulse.
module wash_sequencer #(
    parameter int NUM_PASSES   = 2,
    parameter int PASS_W       = 4,
    parameter int CNT_W        = 16,
    parameter int SHAKE_CYCLES = 100,
    parameter int TURN_CYCLES  = 50,
    parameter int FILL_TIMEOUT = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              full,
    input  logic              dry,
    input  logic              pause,
    input  logic              abort,
    output logic              valve,
    output logic              shake_mode,
    output logic              turn_mode,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [PASS_W-1:0] pass_count
);

    // state | meaning
    // IDLE  | waiting for start
    // FILL  | inlet valve open until full, or FAULT on timeout
    // SHAKE | agitate for SHAKE_CYCLES, then next pass or TURN
    // TURN  | spin at least TURN_CYCLES, leave once dry
    // FAULT | fill timed out, waiting for abort
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SHAKE = 3'd2,
        S_TURN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SHAKE_LAST = CNT_W'(SHAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'(NUM_PASSES - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            pass_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state      <= S_FILL;
                        timer      <= '0;
                        pass_count <= '0;
                    end
                end
                S_FILL, S_SHAKE, S_TURN: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        timer      <= '0;
                        pass_count <= '0;
                    end else if (!pause) begin
                        case (state)
                            S_FILL: begin
                                if (full) begin
                                    state <= S_SHAKE;
                                    timer <= '0;
                                end else if (timer == FILL_LAST) begin
                                    state <= S_FAULT;
                                    timer <= '0;
                                end else begin
                                    timer <= timer + 1'b1;
                                end
                            end
                            S_SHAKE: begin
                                if (timer == SHAKE_LAST) begin
                                    timer <= '0;
                                    if (pass_count == PASS_LAST) begin
                                        state <= S_TURN;
                                    end else begin
                                        state      <= S_FILL;
                                        pass_count <= pass_count + 1'b1;
                                    end
                                end else begin
                                    timer <= timer + 1'b1;
                                end
                            end
                            default: begin
                                // TURN: timer saturates so early dry is held off until the minimum
                                if (timer == TURN_LAST) begin
                                    if (dry) begin
                                        state      <= S_IDLE;
                                        timer      <= '0;
                                        pass_count <= '0;
                                        done       <= 1'b1;
                                    end
                                end else begin
                                    timer <= timer + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_FAULT: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        timer      <= '0;
                        pass_count <= '0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    timer      <= '0;
                    pass_count <= '0;
                end
            endcase
        end
    end

    assign valve      = (state == S_FILL)  && !pause;
    assign shake_mode = (state == S_SHAKE) && !pause;
    assign turn_mode  = (state == S_TURN)  && !pause;
    assign busy       = (state == S_FILL) || (state == S_SHAKE) || (state == S_TURN);
    assign error      = (state == S_FAULT);

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with small timer parameters; every vector is
// checked against a hand-computed output pattern.
module tb_wash_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, full, dry, pause, abort;
    logic       valve, shake_mode, turn_mode, busy, done, error;
    logic [3:0] pass_count;

    int vectors     = 0;
    int miscompares = 0;

    // {valve, shake_mode, turn_mode, busy, done, error}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_FILL  = 6'b100100;
    localparam logic [5:0] O_SHAKE = 6'b010100;
    localparam logic [5:0] O_TURN  = 6'b001100;
    localparam logic [5:0] O_HOLD  = 6'b000100;
    localparam logic [5:0] O_DONE  = 6'b000010;
    localparam logic [5:0] O_FAULT = 6'b000001;

    wash_sequencer #(
        .NUM_PASSES  (2),
        .PASS_W      (4),
        .CNT_W       (16),
        .SHAKE_CYCLES(4),
        .TURN_CYCLES (3),
        .FILL_TIMEOUT(6)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .full      (full),
        .dry       (dry),
        .pause     (pause),
        .abort     (abort),
        .valve     (valve),
        .shake_mode(shake_mode),
        .turn_mode (turn_mode),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .pass_count(pass_count)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] flags, input logic [3:0] pc);
        logic [9:0] got;
        logic [9:0] exp;
        #1;
        got = {valve, shake_mode, turn_mode, busy, done, error, pass_count};
        exp = {flags, pc};
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b (v,s,t,busy,done,err,pc)", tag, got, exp);
        end
    endtask

    // From IDLE: start, fill 1 cycle, shake pass 0, fill pass 1; leaves DUT in 2nd FILL cycle 1 (checked).
    task automatic to_second_fill(input string tag);
        start = 1'b1; cyc(); start = 1'b0;
        full = 1'b1; chk({tag, "_fill0"}, O_FILL, 4'd0); cyc(); full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_shake0"}, O_SHAKE, 4'd0); cyc();
        end
        chk({tag, "_fill1"}, O_FILL, 4'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; full = 1'b0; dry = 1'b0; pause = 1'b0; abort = 1'b0;

        // Nominal wash
        cyc(); cyc();
        reset = 1'b0; dry = 1'b1;
        chk("reset_idle", O_IDLE, 4'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("nom_fill0_a", O_FILL, 4'd0); cyc();
        full = 1'b1; chk("nom_fill0_b", O_FILL, 4'd0); cyc(); full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("nom_shake0", O_SHAKE, 4'd0); cyc();
        end
        chk("nom_fill1_a", O_FILL, 4'd1); cyc();
        full = 1'b1; chk("nom_fill1_b", O_FILL, 4'd1); cyc(); full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("nom_shake1", O_SHAKE, 4'd1); cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk("nom_turn", O_TURN, 4'd1); cyc();
        end
        chk("nom_done", O_DONE, 4'd0); cyc();
        chk("nom_after_done", O_IDLE, 4'd0);
        dry = 1'b0;

        // Fill timeout, start ignored in FAULT, abort clears
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("to_fill", O_FILL, 4'd0); cyc();
        end
        chk("to_fault", O_FAULT, 4'd0);
        start = 1'b1; pause = 1'b1; cyc(); start = 1'b0;
        chk("to_fault_start_pause", O_FAULT, 4'd0);
        pause = 1'b0; abort = 1'b1; cyc(); abort = 1'b0;
        chk("to_abort_idle", O_IDLE, 4'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
        chk("idle_start_abort", O_IDLE, 4'd0);

        // Timeout race: full in the 6th FILL cycle wins
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) full = 1'b1;
            chk("race_fill", O_FILL, 4'd0); cyc();
        end
        full = 1'b0;
        chk("race_shake", O_SHAKE, 4'd0);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("race_abort_shake", O_IDLE, 4'd0);

        // Pause in FILL suppresses timeout
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("pf_fill", O_FILL, 4'd0); cyc();
        end
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pf_hold", O_HOLD, 4'd0); cyc();
        end
        pause = 1'b0; full = 1'b1;
        chk("pf_resume", O_FILL, 4'd0); cyc(); full = 1'b0;
        chk("pf_shake", O_SHAKE, 4'd0);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("pf_abort", O_IDLE, 4'd0);

        // Pause in SHAKE after two shake cycles, then early/late dry in TURN
        start = 1'b1; cyc(); start = 1'b0;
        full = 1'b1; chk("ps_fill", O_FILL, 4'd0); cyc(); full = 1'b0;
        chk("ps_shake1", O_SHAKE, 4'd0); cyc();
        chk("ps_shake2", O_SHAKE, 4'd0); cyc();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ps_hold", O_HOLD, 4'd0); cyc();
        end
        pause = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("ps_resume", O_SHAKE, 4'd0); cyc();
        end
        full = 1'b1; chk("ps_fill1", O_FILL, 4'd1); cyc(); full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ps_shake_p1", O_SHAKE, 4'd1); cyc();
        end
        for (int i = 0; i < 6; i++) begin
            chk("dry_wait_turn", O_TURN, 4'd1); cyc();
        end
        dry = 1'b1;
        chk("dry_turn7", O_TURN, 4'd1); cyc(); dry = 1'b0;
        chk("dry_done", O_DONE, 4'd0); cyc();
        chk("dry_idle", O_IDLE, 4'd0);

        // Abort during 2nd FILL: no done, pass_count cleared
        to_second_fill("ab");
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("ab_idle", O_IDLE, 4'd0); cyc();
        chk("ab_no_done", O_IDLE, 4'd0);

        // Reset during TURN, restart from pass 0
        to_second_fill("rs");
        full = 1'b1; cyc(); full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rs_shake1", O_SHAKE, 4'd1); cyc();
        end
        chk("rs_turn", O_TURN, 4'd1);
        reset = 1'b1; start = 1'b1; cyc(); reset = 1'b0; start = 1'b0;
        chk("rs_idle", O_IDLE, 4'd0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("rs_restart", O_FILL, 4'd0);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("rs_final", O_IDLE, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
